// File: rtl/snake_pkg.sv
// Shared types and play-field defaults for the snake food spawner.
package snake_pkg;

   localparam int unsigned COORD_W = 10;

   localparam logic [COORD_W-1:0] DEF_X_MIN = 10'd0;
   localparam logic [COORD_W-1:0] DEF_X_MAX = 10'd620;
   localparam logic [COORD_W-1:0] DEF_Y_MIN = 10'd0;
   localparam logic [COORD_W-1:0] DEF_Y_MAX = 10'd460;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_BOUND,
      ST_SCAN,
      ST_DONE,
      ST_FAIL
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

   // v+1 > lo stands in for v >= lo so a zero lower bound never folds to a constant compare
   function automatic logic coord_in_range(input logic [COORD_W-1:0] v,
                                           input logic [COORD_W-1:0] lo,
                                           input logic [COORD_W-1:0] hi);
      return (((COORD_W+1)'(v) + (COORD_W+1)'(1)) > (COORD_W+1)'(lo)) && (v <= hi);
   endfunction

endpackage

// File: rtl/food_spawn_ctrl_seg_scan.sv
// Walks the snake body RAM one address per cycle and compares each returned
// segment against the candidate one cycle later; a hit stops further reads.
module seg_scan
   import snake_pkg::*;
#(
   parameter int unsigned LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  coord_t           i_cand,
   input  logic [COORD_W-1:0] i_seg_x,
   input  logic [COORD_W-1:0] i_seg_y,
   output logic             o_seg_rd_c,
   output logic [LEN_W-1:0] o_seg_addr,
   output logic             o_hit_c,
   output logic             o_done_c
);

   logic             r_rd;
   logic [LEN_W-1:0] r_addr;
   logic             r_cmp_v;
   logic             r_cmp_last;

   logic             w_hit;
   logic             w_rd;
   logic [LEN_W-1:0] w_last_addr;

   assign w_last_addr = i_len - LEN_W'(1);
   assign w_hit       = r_cmp_v && (i_seg_x == i_cand.x) && (i_seg_y == i_cand.y);
   // the read scheduled in the hit cycle is dropped before it reaches the RAM
   assign w_rd        = r_rd && !w_hit;

   assign o_seg_rd_c = w_rd;
   assign o_seg_addr = r_addr;
   assign o_hit_c    = w_hit;
   assign o_done_c   = r_cmp_v && r_cmp_last && !w_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd       <= 1'b0;
         r_addr     <= '0;
         r_cmp_v    <= 1'b0;
         r_cmp_last <= 1'b0;
      end else begin
         r_cmp_v    <= w_rd;
         r_cmp_last <= w_rd && (r_addr == w_last_addr);
         if (i_start) begin
            r_rd   <= 1'b1;
            r_addr <= '0;
         end else if (r_rd && (w_hit || (r_addr == w_last_addr))) begin
            r_rd <= 1'b0;
         end else if (r_rd) begin
            r_addr <= r_addr + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: drives random_box, bound-checks each candidate,
// scans the snake body for collisions and retries up to MAX_RETRY times.
module food_spawn_ctrl
   import snake_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_MIN     = DEF_X_MIN,
   parameter logic [COORD_W-1:0] X_MAX     = DEF_X_MAX,
   parameter logic [COORD_W-1:0] Y_MIN     = DEF_Y_MIN,
   parameter logic [COORD_W-1:0] Y_MAX     = DEF_Y_MAX,
   parameter int unsigned        LEN_W     = 6,
   parameter int unsigned        MAX_RETRY = 8,
   parameter int unsigned        DRIVE_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spawn_req,
   input  logic [LEN_W-1:0]   snake_len,
   output logic               drive,
   input  logic [COORD_W-1:0] box_x,
   input  logic [COORD_W-1:0] box_y,
   output logic               seg_rd,
   output logic [LEN_W-1:0]   seg_addr,
   input  logic [COORD_W-1:0] seg_x,
   input  logic [COORD_W-1:0] seg_y,
   output logic [COORD_W-1:0] food_x,
   output logic [COORD_W-1:0] food_y,
   output logic               food_valid,
   output logic               busy,
   output logic               spawn_fail
);

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int unsigned WAIT_W  = (DRIVE_LAT > 1) ? $clog2(DRIVE_LAT) : 1;

   state_t             r_state, w_state_n;
   logic [RETRY_W-1:0] r_retry, w_retry_n;
   logic [WAIT_W-1:0]  r_wait,  w_wait_n;
   logic [LEN_W-1:0]   r_len,   w_len_n;
   coord_t             r_cand,  w_cand_n;
   coord_t             r_food,  w_food_n;
   logic               r_food_valid, w_food_valid_n;
   logic               r_drive;
   logic               r_busy;
   logic               r_spawn_fail;

   logic               w_in_bounds;
   logic               w_reject;
   logic               w_scan_start;
   logic               w_scan_hit_c;
   logic               w_scan_done_c;

   assign w_in_bounds = coord_in_range(r_cand.x, X_MIN, X_MAX) &&
                        coord_in_range(r_cand.y, Y_MIN, Y_MAX);

   seg_scan #(
      .LEN_W (LEN_W)
   ) u_seg_scan (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_scan_start),
      .i_len      (r_len),
      .i_cand     (r_cand),
      .i_seg_x    (seg_x),
      .i_seg_y    (seg_y),
      .o_seg_rd_c (seg_rd),
      .o_seg_addr (seg_addr),
      .o_hit_c    (w_scan_hit_c),
      .o_done_c   (w_scan_done_c)
   );

   // next-state and datapath next values
   always_comb begin
      w_state_n      = r_state;
      w_retry_n      = r_retry;
      w_wait_n       = r_wait;
      w_len_n        = r_len;
      w_cand_n       = r_cand;
      w_food_n       = r_food;
      w_food_valid_n = r_food_valid;
      w_scan_start   = 1'b0;
      w_reject       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (spawn_req) begin
               w_len_n        = snake_len;
               w_food_valid_n = 1'b0;
               w_retry_n      = '0;
               w_state_n      = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            w_wait_n  = WAIT_W'(DRIVE_LAT - 1);
            w_state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait == '0) begin
               w_cand_n.x = box_x;
               w_cand_n.y = box_y;
               w_state_n  = ST_BOUND;
            end else begin
               w_wait_n = r_wait - WAIT_W'(1);
            end
         end
         ST_BOUND: begin
            if (!w_in_bounds) begin
               w_reject = 1'b1;
            end else if (r_len == '0) begin
               w_state_n = ST_DONE;
            end else begin
               w_scan_start = 1'b1;
               w_state_n    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_scan_hit_c) begin
               w_reject = 1'b1;
            end else if (w_scan_done_c) begin
               w_state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            w_food_n       = r_cand;
            w_food_valid_n = 1'b1;
            w_state_n      = ST_IDLE;
         end
         ST_FAIL: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase

      if (w_reject) begin
         w_retry_n = r_retry + RETRY_W'(1);
         w_state_n = (w_retry_n == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_DRIVE;
      end
   end

   // strobes are registered off the next state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_retry      <= '0;
         r_wait       <= '0;
         r_len        <= '0;
         r_cand       <= '0;
         r_food       <= '0;
         r_food_valid <= 1'b0;
         r_drive      <= 1'b0;
         r_busy       <= 1'b0;
         r_spawn_fail <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_retry      <= w_retry_n;
         r_wait       <= w_wait_n;
         r_len        <= w_len_n;
         r_cand       <= w_cand_n;
         r_food       <= w_food_n;
         r_food_valid <= w_food_valid_n;
         r_drive      <= (w_state_n == ST_DRIVE);
         r_busy       <= (w_state_n != ST_IDLE);
         r_spawn_fail <= (w_state_n == ST_FAIL);
      end
   end

   assign drive      = r_drive;
   assign food_x     = r_food.x;
   assign food_y     = r_food.y;
   assign food_valid = r_food_valid;
   assign busy       = r_busy;
   assign spawn_fail = r_spawn_fail;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Scoreboard bench for food_spawn_ctrl: a request-level model predicts the
// outcome, drive/read counts and latency; a monitor checks each published result.
module tb_food_spawn_ctrl;

   localparam int DL   = 2;
   localparam int MAXR = 8;
   localparam int XMAX = 620;
   localparam int YMAX = 460;

   typedef struct {
      bit fail;
      int x;
      int y;
      int drives;
      int reads;
      int lat;
      int t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spawn_req = 1'b0;
   logic [5:0] snake_len = '0;
   logic       drive;
   logic [9:0] box_x = '0;
   logic [9:0] box_y = '0;
   logic       seg_rd;
   logic [5:0] seg_addr;
   logic [9:0] seg_x = '0;
   logic [9:0] seg_y = '0;
   logic [9:0] food_x;
   logic [9:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       spawn_fail;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   int   mem_x [64];
   int   mem_y [64];
   int   cx [MAXR];
   int   cy [MAXR];
   int   box_qx [$];
   int   box_qy [$];
   exp_t sb_q [$];

   logic [9:0] pend_x = '0;
   logic [9:0] pend_y = '0;
   int         dl_cnt = 0;

   food_spawn_ctrl #(
      .X_MIN     (10'd0),
      .X_MAX     (10'd620),
      .Y_MIN     (10'd0),
      .Y_MAX     (10'd460),
      .LEN_W     (6),
      .MAX_RETRY (MAXR),
      .DRIVE_LAT (DL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spawn_req  (spawn_req),
      .snake_len  (snake_len),
      .drive      (drive),
      .box_x      (box_x),
      .box_y      (box_y),
      .seg_rd     (seg_rd),
      .seg_addr   (seg_addr),
      .seg_x      (seg_x),
      .seg_y      (seg_y),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .busy       (busy),
      .spawn_fail (spawn_fail)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // body RAM: one-cycle read latency
   always @(posedge clk) begin
      if (seg_rd) begin
         seg_x <= 10'(mem_x[seg_addr]);
         seg_y <= 10'(mem_y[seg_addr]);
      end
   end

   // random_box: garbage until DRIVE_LAT edges after the drive pulse is seen
   always @(posedge clk) begin
      if (rst) begin
         dl_cnt <= 0;
      end else if (drive) begin
         if (box_qx.size() > 0) begin
            pend_x <= 10'(box_qx.pop_front());
            pend_y <= 10'(box_qy.pop_front());
         end else begin
            pend_x <= 10'h3ff;
            pend_y <= 10'h3ff;
         end
         box_x  <= 10'($urandom);
         box_y  <= 10'($urandom);
         dl_cnt <= DL - 1;
      end else if (dl_cnt > 0) begin
         dl_cnt <= dl_cnt - 1;
         if (dl_cnt == 1) begin
            box_x <= pend_x;
            box_y <= pend_y;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_field(input int x, input int y);
      return (x >= 0) && (x <= XMAX) && (y >= 0) && (y <= YMAX);
   endfunction

   function automatic int first_hit(input int len, input int x, input int y);
      for (int j = 0; j < len; j++)
         if (mem_x[j] == x && mem_y[j] == y) return j;
      return -1;
   endfunction

   // predict the whole request from cx/cy, queue candidates, then pulse spawn_req
   task automatic issue(input int len);
      exp_t e;
      int   used;
      int   j;
      bit   ok;
      e.fail = 1'b0; e.x = 0; e.y = 0; e.drives = 0; e.reads = 0; e.lat = 0; e.t0 = 0;
      ok   = 1'b0;
      used = 0;
      for (int i = 0; i < MAXR && !ok; i++) begin
         used  = i + 1;
         e.lat += 1 + DL + 1;
         if (in_field(cx[i], cy[i])) begin
            j = first_hit(len, cx[i], cy[i]);
            if (j < 0) begin
               e.reads += len;
               if (len > 0) e.lat += len + 1;
               ok  = 1'b1;
               e.x = cx[i];
               e.y = cy[i];
            end else begin
               e.reads += j + 1;
               e.lat   += j + 2;
            end
         end
      end
      if (ok) e.lat += 1;
      e.fail   = !ok;
      e.drives = used;
      for (int i = 0; i < used; i++) begin
         box_qx.push_back(cx[i]);
         box_qy.push_back(cy[i]);
      end
      @(negedge clk);
      snake_len = 6'(len);
      spawn_req = 1'b1;
      @(posedge clk);
      #1;
      e.t0 = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      spawn_req = 1'b0;
      snake_len = 6'($urandom);
   endtask

   // wait for idle while throwing ignored requests at the busy block
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         spawn_req = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      spawn_req = 1'b0;
      if (busy) chk("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic set_snake3();
      mem_x[0] = 40; mem_y[0] = 40;
      mem_x[1] = 60; mem_y[1] = 40;
      mem_x[2] = 80; mem_y[2] = 40;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_drive"},      int'(drive),      0);
      chk({tag, "_seg_rd"},     int'(seg_rd),     0);
      chk({tag, "_seg_addr"},   int'(seg_addr),   0);
      chk({tag, "_food_x"},     int'(food_x),     0);
      chk({tag, "_food_y"},     int'(food_y),     0);
      chk({tag, "_food_valid"}, int'(food_valid), 0);
      chk({tag, "_busy"},       int'(busy),       0);
      chk({tag, "_spawn_fail"}, int'(spawn_fail), 0);
   endtask

   task automatic rand_req();
      int len;
      int r;
      int k;
      int j;
      r   = $urandom_range(0, 9);
      len = (r == 0) ? 0 : ((r == 9) ? $urandom_range(20, 63) : $urandom_range(1, 8));
      for (int s = 0; s < len; s++) begin
         mem_x[s] = 20 * $urandom_range(0, 31);
         mem_y[s] = 20 * $urandom_range(0, 23);
      end
      for (int i = 0; i < MAXR; i++) begin
         k = $urandom_range(0, 99);
         if (k < 40 && len > 0) begin
            j = $urandom_range(0, len - 1);
            cx[i] = mem_x[j];
            cy[i] = mem_y[j];
         end else if (k < 55) begin
            if ($urandom_range(0, 1) == 1) begin
               cx[i] = $urandom_range(XMAX + 1, 1023);
               cy[i] = $urandom_range(0, YMAX);
            end else begin
               cx[i] = $urandom_range(0, XMAX);
               cy[i] = $urandom_range(YMAX + 1, 1023);
            end
         end else if (k < 70) begin
            r = $urandom_range(0, 2);
            cx[i] = (r == 0) ? 0 : ((r == 1) ? XMAX : XMAX + 1);
            r = $urandom_range(0, 2);
            cy[i] = (r == 0) ? 0 : ((r == 1) ? YMAX : YMAX + 1);
         end else begin
            cx[i] = 20 * $urandom_range(0, 31);
            cy[i] = 20 * $urandom_range(0, 23);
         end
      end
      issue(len);
      wait_idle();
   endtask

   // monitor: address sequencing, drive/read counting, result scoreboard
   int   drv_cnt = 0;
   int   rd_cnt = 0;
   bit   prev_rd = 1'b0;
   int   prev_addr = 0;
   bit   fv_prev = 1'b0;
   bit   chk_after_fail = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         drv_cnt        = 0;
         rd_cnt         = 0;
         prev_rd        = 1'b0;
         fv_prev        = 1'b0;
         chk_after_fail = 1'b0;
      end else begin
         if (chk_after_fail) begin
            chk("post_fail_pulse", int'(spawn_fail), 0);
            chk("post_fail_busy",  int'(busy),       0);
            chk("post_fail_fv",    int'(food_valid), 0);
            chk_after_fail = 1'b0;
         end
         if (drive) drv_cnt++;
         if (seg_rd) begin
            chk("seg_addr_seq", int'(seg_addr), prev_rd ? prev_addr + 1 : 0);
            rd_cnt++;
         end
         prev_rd   = seg_rd;
         prev_addr = int'(seg_addr);
         if ((food_valid && !fv_prev) || spawn_fail) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("outcome_fail", int'(spawn_fail), int'(e.fail));
               chk("drives",       drv_cnt,          e.drives);
               chk("reads",        rd_cnt,           e.reads);
               chk("latency",      cyc - e.t0,       e.lat);
               if (e.fail) begin
                  chk("fail_fv", int'(food_valid), 0);
                  chk_after_fail = 1'b1;
               end else begin
                  chk("food_x", int'(food_x), e.x);
                  chk("food_y", int'(food_y), e.y);
               end
            end
            drv_cnt = 0;
            rd_cnt  = 0;
         end
         fv_prev = food_valid;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_x[i] = 1000;
         mem_y[i] = 1000;
      end
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // empty snake, single accepted candidate
      cx[0] = 100; cy[0] = 200;
      issue(0);
      wait_idle();

      // three segments, candidate clear of all of them
      set_snake3();
      cx[0] = 100; cy[0] = 200;
      issue(3);
      wait_idle();

      // hit on segment 1, then a clean candidate
      cx[0] = 60;  cy[0] = 40;
      cx[1] = 300; cy[1] = 300;
      issue(3);
      wait_idle();

      // outside X_MAX, then exactly on the inclusive corner
      cx[0] = 640; cy[0] = 10;
      cx[1] = 620; cy[1] = 460;
      issue(3);
      wait_idle();

      // every candidate lands on segment 0
      for (int i = 0; i < MAXR; i++) begin
         cx[i] = 40;
         cy[i] = 40;
      end
      issue(3);
      wait_idle();

      // reset in the middle of WAIT abandons the request
      cx[0] = 100; cy[0] = 200;
      issue(3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      sb_q.delete();
      box_qx.delete();
      box_qy.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      cx[0] = 5; cy[0] = 5;
      mem_x[0] = 5; mem_y[0] = 6;
      mem_x[1] = 6; mem_y[1] = 5;
      issue(2);
      wait_idle();

      for (int n = 0; n < 60; n++) rand_req();

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
